// File: rtl/cmp_pkg.sv
// Shared definitions for the compare arbiter: compare-mode encodings and
// the output slot state type.
package cmp_pkg;

  localparam logic [1:0] CMP_EQ  = 2'd0;
  localparam logic [1:0] CMP_XGT = 2'd1;
  localparam logic [1:0] CMP_YGT = 2'd2;
  localparam logic [1:0] CMP_MAX = 2'd3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/cmp_unit.sv
// Combinational unsigned comparison unit. The 1-bit results are
// zero-extended; MAX returns the larger operand.
module cmp_unit
  import cmp_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_y,
  output logic [DATA_W-1:0] o_result
);

  always_comb begin
    // NOTE: defaulting every output before the case keeps this block free of inferred latches.
    o_result = '0;
    unique case (i_mode)
      CMP_EQ:  o_result[0] = (i_x == i_y);
      CMP_XGT: o_result[0] = (i_x > i_y);
      CMP_YGT: o_result[0] = (i_y > i_x);
      CMP_MAX: o_result    = (i_x > i_y) ? i_x : i_y;
      default: o_result    = '0;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter sharing one cmp_unit, with a single
// registered, backpressured response slot.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_mode,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_mode,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data
);

  slot_state_t       r_state;
  logic              r_prio;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_slot_free;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_grant;
  logic [1:0]        w_mode;
  logic [DATA_W-1:0] w_x;
  logic [DATA_W-1:0] w_y;
  logic [DATA_W-1:0] w_result;

  // Gating with rst_n keeps both readies low while reset is held, even
  // though the slot reads as empty then.
  assign w_slot_free = rst_n && ((r_state == SLOT_EMPTY) || rsp_ready);
  assign w_grant0    = w_slot_free && req0_valid && (!req1_valid || (r_prio == 1'b0));
  assign w_grant1    = w_slot_free && req1_valid && (!req0_valid || (r_prio == 1'b1));
  assign w_grant     = w_grant0 || w_grant1;

  assign w_mode = w_grant1 ? req1_mode : req0_mode;
  assign w_x    = w_grant1 ? req1_x    : req0_x;
  assign w_y    = w_grant1 ? req1_y    : req0_y;

  cmp_unit #(
    .DATA_W (DATA_W)
  ) u_cmp_unit (
    .i_mode   (w_mode),
    .i_x      (w_x),
    .i_y      (w_y),
    .o_result (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SLOT_EMPTY;
      r_prio     <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
    end else if (w_grant) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state    <= SLOT_FULL;
      r_rsp_data <= w_result;
      r_rsp_id   <= w_grant1;
      r_prio     <= ~w_grant1;
    end else if (rsp_ready) begin
      r_state <= SLOT_EMPTY;
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp_valid  = (r_state == SLOT_FULL);
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;

endmodule
